serial_frame_source: RTL and testbench
======================================

# serial_frame_source

Upstream stage that feeds the zero-detector Moore FSM. It accepts parallel words through a valid/ready load handshake and serializes each word MSB-first onto a single-bit line, one bit per clock. It also emits per-bit valid and frame-boundary strobes. The idle line is held at 1 so the downstream detector never sees spurious zeros between frames.

## Interface
Parameters:
- WIDTH, 8, bits per word; legal range 2..32.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  WIDTH  word to serialize.
- load_valid  input  1  data_in is valid.
- load_ready  output  1  block can accept a word this cycle.
- x_out  output  1  serial bit; drives the detector's x_in.
- bit_valid  output  1  x_out carries a frame bit.
- frame_start  output  1  x_out is the first bit of a frame.
- frame_end  output  1  x_out is the last bit of a frame.
- busy  output  1  a frame is in flight or a word is pending.

## Operation
- Storage: one holding register (hold, hold_full) and one shift register (shreg) with a bit counter (bit_cnt, $clog2(WIDTH)+1 bits).
- Handshake:
  - A word is accepted on a rising edge where load_valid && load_ready.
  - load_ready = !hold_full. It is a function of registered state only; there is no combinational path from load_valid.
  - data_in is sampled only on accepted edges.
- State machine (ser_state_t):
  - IDLE -> SHIFT: on acceptance when hold is empty, the word bypasses hold and loads shreg directly. On any edge in IDLE with hold_full, shreg loads from hold.
  - SHIFT: shifts left one bit per edge. After the last data bit, the FSM goes to PARITY (macro on). Otherwise it goes to SHIFT again if hold_full (loads hold, clears hold_full), or to IDLE.
  - PARITY (macro only): one cycle, then the same reload/IDLE decision as above.
- Frame bits:
  - x_out = shreg[WIDTH-1] in SHIFT, the parity bit in PARITY, and 1 in IDLE.
  - bit_valid = 1 in SHIFT/PARITY.
  - frame_start = 1 on the first data bit.
  - frame_end = 1 on the final bit of the frame (last data bit, or the parity bit).
- Simultaneous events: acceptance on the same edge as the final bit is allowed only if hold was empty before that edge. The new word lands in hold and follows with zero gap.
- busy = (state != IDLE) || hold_full.

## Timing
- Reset values:
  - state = IDLE, hold_full = 0, load_ready = 1.
  - x_out = 1, bit_valid = 0, frame_start = 0, frame_end = 0, busy = 0.
  - shreg, hold and bit_cnt are cleared to 0.
- All outputs are registered except load_ready, which is decoded from hold_full.
- Latency: a word accepted at edge N in IDLE with hold empty shows its MSB on x_out after edge N. Data bit k appears after edge N+k.
- A frame is WIDTH cycles long, or WIDTH+1 with parity.
- Back-to-back frames have no idle cycle between them when the next word is in hold by the final-bit edge.
- Reset asserted mid-frame takes effect immediately, without waiting for the clock: the frame is truncated and the pending hold word is discarded. After deassertion the block restarts from IDLE.

## Configuration
- SER_PARITY_EN defined:
  - The PARITY state is compiled in.
  - One even-parity bit (^word, so the total count of ones is even) is appended after the LSB.
  - frame_end moves to the parity bit.
- SER_PARITY_EN undefined:
  - The PARITY state and the parity logic are absent.
  - A frame is exactly WIDTH bits.

## Structure
- Package ser_pkg holds:
  - the ser_state_t enum (IDLE, SHIFT, PARITY);
  - the IDLE_LINE = 1'b1 constant;
  - the function parity_even(word).
- Natural sub-module: ser_hold_reg, the one-entry holding register with its full flag and load/drain controls.
- The FSM, shift register and counter stay in serial_frame_source.

## Test plan
All scenarios use WIDTH = 8.
- Reset, then one load of 8'hA5 from IDLE:
  - x_out = 1,0,1,0,0,1,0,1 on 8 consecutive cycles;
  - frame_start on the first bit, frame_end on the eighth;
  - then x_out = 1 and bit_valid = 0.
- Loads of 8'hF0 then 8'h0F, the second issued during the first frame:
  - 16 contiguous valid bits 11110000 00001111;
  - frame_start pulses at bit 1 and bit 9.
- Three words offered back-to-back with load_valid held high:
  - load_ready drops after the second acceptance;
  - the third word is accepted only after the first frame ends;
  - no word is lost or duplicated.
- Reset asserted mid-frame after 3 bits of 8'hC3:
  - bit_valid = 0 and x_out = 1 immediately;
  - hold is empty and load_ready = 1;
  - a following load of 8'h81 serializes correctly.
- With SER_PARITY_EN, load 8'h07:
  - bits 00000111 then parity 1;
  - frame_end on the 9th bit.
- With SER_PARITY_EN, load 8'h03:
  - parity bit 0.

Source files
------------

// File: rtl/serial_frame_source_pkg.sv
// Shared types and helpers for serial_frame_source.
// The SER_PARITY_EN macro adds the PARITY state to ser_state_t.
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef SER_PARITY_EN
    ,
    PARITY = 2'd2
`endif
  } ser_state_t;

  localparam logic IDLE_LINE = 1'b1;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic parity_even(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/serial_frame_source_hold_reg.sv
// One-entry holding register for serial_frame_source.
// Its full flag drives load_ready; it has no configuration macros.
module ser_hold_reg
  import ser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain_en,
  output logic             full,
  output logic             full_next,
  output logic [WIDTH-1:0] data
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  // A load and a drain can never coincide: loads need an empty entry, drains a full one.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load_en) begin
      full_d = 1'b1;
      data_d = load_data;
    end else if (drain_en) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full      = full_q;
  assign full_next = full_d;
  assign data      = data_q;

endmodule

// File: rtl/serial_frame_source.sv
// Serializes parallel words MSB-first with per-bit valid and frame strobes.
// Define SER_PARITY_EN to append an even-parity bit to every frame.
module serial_frame_source
  import ser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             x_out_q, x_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_end_q, frame_end_d;
  logic             busy_q, busy_d;
`ifdef SER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic             hold_full, hold_full_next;
  logic [WIDTH-1:0] hold_data;
  logic             accept, hold_load, hold_drain;
  logic             start_frame, frame_done;
  logic [WIDTH-1:0] start_word;

  assign load_ready = !hold_full;
  assign accept     = load_valid && load_ready;
  // In IDLE an accepted word bypasses the holding register straight into shreg.
  assign hold_load  = accept && (state_q != IDLE);

  ser_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clock    (clock),
    .reset    (reset),
    .load_en  (hold_load),
    .load_data(data_in),
    .drain_en (hold_drain),
    .full     (hold_full),
    .full_next(hold_full_next),
    .data     (hold_data)
  );

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    x_out_d       = IDLE_LINE;
    bit_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    hold_drain    = 1'b0;
    start_frame   = 1'b0;
    frame_done    = 1'b0;
    start_word    = data_in;
`ifdef SER_PARITY_EN
    parity_d      = parity_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (hold_full) begin
          start_frame = 1'b1;
          hold_drain  = 1'b1;
          start_word  = hold_data;
        end else if (accept) begin
          start_frame = 1'b1;
        end
      end
      SHIFT: begin
        if (bit_cnt_q != LAST_BIT) begin
          shreg_d     = {shreg_q[WIDTH-2:0], 1'b0};
          bit_cnt_d   = bit_cnt_q + CNT_W'(1);
          x_out_d     = shreg_q[WIDTH-2];
          bit_valid_d = 1'b1;
`ifdef SER_PARITY_EN
          frame_end_d = 1'b0;
`else
          frame_end_d = (bit_cnt_d == LAST_BIT);
`endif
        end else begin
`ifdef SER_PARITY_EN
          state_d     = PARITY;
          x_out_d     = parity_q;
          bit_valid_d = 1'b1;
          frame_end_d = 1'b1;
`else
          frame_done  = 1'b1;
`endif
        end
      end
`ifdef SER_PARITY_EN
      PARITY: begin
        frame_done = 1'b1;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    // The final bit has just left the line: chain a waiting word with no gap.
    if (frame_done) begin
      if (hold_full) begin
        start_frame = 1'b1;
        hold_drain  = 1'b1;
        start_word  = hold_data;
      end else begin
        state_d = IDLE;
      end
    end

    if (start_frame) begin
      state_d       = SHIFT;
      shreg_d       = start_word;
      bit_cnt_d     = '0;
      x_out_d       = start_word[WIDTH-1];
      bit_valid_d   = 1'b1;
      frame_start_d = 1'b1;
      frame_end_d   = 1'b0;
`ifdef SER_PARITY_EN
      parity_d      = parity_even(32'(start_word));
`endif
    end
  end

  assign busy_d = (state_d != IDLE) || hold_full_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      x_out_q       <= IDLE_LINE;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      busy_q        <= 1'b0;
`ifdef SER_PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      x_out_q       <= x_out_d;
      bit_valid_q   <= bit_valid_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      busy_q        <= busy_d;
`ifdef SER_PARITY_EN
      parity_q      <= parity_d;
`endif
    end
  end

  assign x_out       = x_out_q;
  assign bit_valid   = bit_valid_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_serial_frame_source.sv
// Self-checking bench for serial_frame_source with WIDTH = 8.
// Follows SER_PARITY_EN: when defined, frames carry a trailing even-parity bit.
module tb_serial_frame_source;

`ifdef SER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FLEN = 8 + PAR;

  typedef struct packed {
    logic b;
    logic s;
    logic e;
  } line_bit_t;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       exp_x;
    logic       exp_bv;
    logic       exp_start;
    logic       exp_end;
    logic       exp_ready;
  } vec_t;

  logic       clock, reset, load_valid, load_ready;
  logic       x_out, bit_valid, frame_start, frame_end, busy;
  logic [7:0] data_in;

  int n_checks = 0;
  int n_fail   = 0;

  line_bit_t   stream[$];
  logic [7:0]  holdq[$];
  logic        ready_seen;
  logic [31:0] col_bits;
  int          col_n, start_mask, end_mask;
  vec_t        vecs[10];
  logic [7:0]  words[3];

  serial_frame_source #(
    .WIDTH(8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .x_out      (x_out),
    .bit_valid  (bit_valid),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .busy       (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_word(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] frame_bits(input logic [7:0] w);
    return (PAR != 0) ? {23'b0, w, ^w} : {24'b0, w};
  endfunction

  // Reference line: every accepted word becomes a queue of line bits.
  function automatic void expand(input logic [7:0] w);
    line_bit_t lb;
    for (int k = 7; k >= 0; k--) begin
      lb.b = w[k];
      lb.s = (k == 7);
      lb.e = (k == 0) && (PAR == 0);
      stream.push_back(lb);
    end
    if (PAR != 0) begin
      lb.b = ^w;
      lb.s = 1'b0;
      lb.e = 1'b1;
      stream.push_back(lb);
    end
  endfunction

  function automatic void model_step(input logic acc, input logic [7:0] d);
    if (stream.size() != 0) begin
      void'(stream.pop_front());
      if (stream.size() == 0 && holdq.size() != 0) expand(holdq.pop_front());
      if (acc) holdq.push_back(d);
    end else if (holdq.size() != 0) begin
      expand(holdq.pop_front());
    end else if (acc) begin
      expand(d);
    end
  endfunction

  function automatic void col_reset();
    col_bits   = '0;
    col_n      = 0;
    start_mask = 0;
    end_mask   = 0;
  endfunction

  // One clock: drive, check ready, advance the model, then compare outputs.
  task automatic apply_stimulus(input logic v, input logic [7:0] d);
    logic acc;
    logic exp_valid;
    load_valid = v;
    data_in    = d;
    #1;
    ready_seen = load_ready;
    check_bit("load_ready", load_ready, holdq.size() == 0);
    acc = v && (holdq.size() == 0);
    @(posedge clock);
    model_step(acc, d);
    @(negedge clock);
    exp_valid = (stream.size() != 0);
    check_bit("bit_valid", bit_valid, exp_valid);
    check_bit("x_out", x_out, exp_valid ? stream[0].b : 1'b1);
    check_bit("frame_start", frame_start, exp_valid ? stream[0].s : 1'b0);
    check_bit("frame_end", frame_end, exp_valid ? stream[0].e : 1'b0);
    check_bit("busy", busy, exp_valid || (holdq.size() != 0));
    if (bit_valid) begin
      col_bits = {col_bits[30:0], x_out};
      if (col_n < 32) begin
        if (frame_start) start_mask |= (1 << col_n);
        if (frame_end) end_mask |= (1 << col_n);
      end
      col_n++;
    end
  endtask

  initial begin
    int idx;
    int acc3_c;
    logic pred;

    reset      = 1'b0;
    load_valid = 1'b0;
    data_in    = '0;
    col_reset();
    #7;
    check_bit("rst_x_out", x_out, 1'b1);
    check_bit("rst_bit_valid", bit_valid, 1'b0);
    check_bit("rst_frame_start", frame_start, 1'b0);
    check_bit("rst_frame_end", frame_end, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_load_ready", load_ready, 1'b1);
    @(negedge clock);
    reset = 1'b1;

    // A5 from IDLE: 1,0,1,0,0,1,0,1 then parity 0 (if enabled) then idle.
    vecs[0] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, (PAR == 0), 1'b1};
    vecs[8] = '{1'b0, 8'h00, (PAR == 0), (PAR != 0), 1'b0, (PAR != 0), 1'b1};
    vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i].valid, vecs[i].data);
      check_bit($sformatf("vec%0d_x", i), x_out, vecs[i].exp_x);
      check_bit($sformatf("vec%0d_valid", i), bit_valid, vecs[i].exp_bv);
      check_bit($sformatf("vec%0d_start", i), frame_start, vecs[i].exp_start);
      check_bit($sformatf("vec%0d_end", i), frame_end, vecs[i].exp_end);
      check_bit($sformatf("vec%0d_ready", i), ready_seen, vecs[i].exp_ready);
    end

    $display("[TB] F0 then 0F, second word loaded mid-frame");
    col_reset();
    apply_stimulus(1'b1, 8'hF0);
    apply_stimulus(1'b1, 8'h0F);
    repeat (2 * FLEN - 2) apply_stimulus(1'b0, 8'h00);
    check_word("f00f_count", col_n, 2 * FLEN);
    check_word("f00f_bits", col_bits, (frame_bits(8'hF0) << FLEN) | frame_bits(8'h0F));
    check_word("f00f_starts", start_mask, 1 | (1 << FLEN));
    apply_stimulus(1'b0, 8'h00);
    check_bit("f00f_idle", bit_valid, 1'b0);

    $display("[TB] three words with load_valid held high");
    col_reset();
    words[0] = 8'h3C;
    words[1] = 8'h96;
    words[2] = 8'h5A;
    idx    = 0;
    acc3_c = -1;
    for (int c = 0; c < 3 * FLEN; c++) begin
      pred = (idx < 3) && (holdq.size() == 0);
      apply_stimulus(idx < 3, words[(idx < 3) ? idx : 0]);
      if (c == 2) check_bit("ready_after_two", ready_seen, 1'b0);
      if (pred) begin
        if (idx == 2) acc3_c = c;
        idx++;
      end
    end
    check_word("three_accepted", idx, 3);
    check_word("third_accept_cycle", acc3_c, FLEN + 1);
    check_word("three_count", col_n, 3 * FLEN);
    check_word("three_bits", col_bits,
               (((frame_bits(words[0]) << FLEN) | frame_bits(words[1])) << FLEN) | frame_bits(words[2]));
    apply_stimulus(1'b0, 8'h00);

    $display("[TB] reset mid-frame");
    col_reset();
    apply_stimulus(1'b1, 8'hC3);
    apply_stimulus(1'b1, 8'h77);
    apply_stimulus(1'b0, 8'h00);
    check_word("c3_partial", col_bits, 32'h6);
    reset = 1'b0;
    #2;
    check_bit("midrst_bit_valid", bit_valid, 1'b0);
    check_bit("midrst_x_out", x_out, 1'b1);
    check_bit("midrst_load_ready", load_ready, 1'b1);
    check_bit("midrst_busy", busy, 1'b0);
    check_bit("midrst_frame_end", frame_end, 1'b0);
    stream.delete();
    holdq.delete();
    #1;
    reset = 1'b1;
    apply_stimulus(1'b0, 8'h00);
    col_reset();
    apply_stimulus(1'b1, 8'h81);
    repeat (FLEN - 1) apply_stimulus(1'b0, 8'h00);
    check_word("w81_count", col_n, FLEN);
    check_word("w81_bits", col_bits, frame_bits(8'h81));
    apply_stimulus(1'b0, 8'h00);

`ifdef SER_PARITY_EN
    $display("[TB] parity frames");
    col_reset();
    apply_stimulus(1'b1, 8'h07);
    repeat (8) apply_stimulus(1'b0, 8'h00);
    check_word("p07_bits", col_bits, 32'h00F);
    check_word("p07_end", end_mask, 1 << 8);
    apply_stimulus(1'b0, 8'h00);
    col_reset();
    apply_stimulus(1'b1, 8'h03);
    repeat (8) apply_stimulus(1'b0, 8'h00);
    check_word("p03_bits", col_bits, 32'h006);
    apply_stimulus(1'b0, 8'h00);
`endif

    $display("[TB] randomized traffic");
    for (int c = 0; c < 400; c++) begin
      apply_stimulus($urandom_range(0, 3) != 0, 8'($urandom));
    end
    repeat (2 * FLEN + 2) apply_stimulus(1'b0, 8'h00);
    check_bit("drain_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
